cnt_updown_core: RTL and testbench
==================================

# cnt_updown_core

Counter DUT driven by the counter UVC's clock/reset interface. Loadable, parameterised up/down counter with run/stop control, wrap or saturate mode, one-cycle terminal-count pulse, and a single-entry valid/ready event port. The event port reports every wrap or saturation to the downstream monitor or scoreboard.

## Interface
- WIDTH, 8, counter and data width (≥2)
- clk  in  1  free-running clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- start  in  1  request IDLE→RUN
- stop  in  1  request RUN→IDLE
- en  in  1  count enable, honoured only in RUN
- up_dn  in  1  1 = increment, 0 = decrement
- sat_mode  in  1  1 = saturate at bound, 0 = wrap
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  load value
- clr_ovf  in  1  clears evt_ovf
- count  out  WIDTH  registered count
- running  out  1  high while state is RUN
- tc  out  1  one-cycle terminal-count pulse
- evt_valid  out  1  event pending
- evt_data  out  WIDTH  count value at the event
- evt_ready  in  1  consumer accepts the event
- evt_ovf  out  1  sticky: an event was dropped

## Operation
- Reset values: count = 0, state = IDLE, running = 0, tc = 0, evt_valid = 0, evt_data = 0, evt_ovf = 0.
- Reset priority: rst overrides every input in the same cycle, including mid-handshake; a pending event is discarded.
- States:
  - IDLE: start & !stop → RUN.
  - RUN: stop → IDLE. A saturation event → HALT.
  - HALT: count frozen; start and en ignored; load → IDLE.
- Update priority per cycle: rst > load > count step.
- load: count ← load_val, no tc and no event. State unchanged, except HALT → IDLE.
- Count step: happens when state = RUN, en = 1 and load = 0. Modulo-2^WIDTH arithmetic, step of 1.
- Wrap mode (sat_mode = 0): event when up at 2^WIDTH−1 (next value 0) or down at 0 (next value 2^WIDTH−1).
- Saturate mode (sat_mode = 1):
  - Up at 2^WIDTH−1 or down at 0 holds the value.
  - tc fires once on the hold attempt and state goes to HALT.
  - Reaching the bound by a normal step is not an event; the next step attempt is.
- Event: tc = 1 for one cycle and a push to the event register, with evt_data = count after the update.
- Event register (one entry):
  - evt_valid stays high until the cycle where evt_valid & evt_ready.
  - A push while the register is empty, or in the same cycle it drains (evt_ready = 1), loads the new data and keeps evt_valid high.
  - A push while the register is full and evt_ready = 0 drops the new event, keeps the old data, and sets evt_ovf.
  - evt_data is stable while evt_valid = 1 and not accepted.
- evt_ovf: cleared by clr_ovf. If clr_ovf and a drop occur in the same cycle, the set wins.
- up_dn and sat_mode are sampled every cycle. A change mid-run takes effect on the next step.

## Timing
- All outputs are registered; there is no combinational input→output path.
- count, tc and evt_valid/evt_data change on the clock edge following the sampled inputs (latency 1).
- running follows state in the same cycle as the state update.
- tc and the first cycle of evt_valid coincide. evt_data equals count in that cycle.
- Event throughput: one event per cycle when evt_ready is held high.

## Structure
- Package cnt_pkg:
  - state enum cnt_state_e {CNT_IDLE, CNT_RUN, CNT_HALT}
  - localparam CNT_WIDTH_DEF = 8
  - bound helper function cnt_max(width) returning 2^width−1
- Sub-module cnt_evt_reg: the single-entry valid/ready holding register with drop/overflow detection, parameterised by WIDTH.
- Top-level cnt_updown_core holds the FSM, the counter datapath and event generation.

## Test plan
- Reset mid-operation: count at 0x37 in RUN with an event pending, assert rst one cycle → next cycle all outputs at reset values; state IDLE.
- Wrap up: WIDTH = 8, load 0xFE, start, en high, evt_ready = 1 → count goes 0xFF, then 0x00 with tc = 1 and evt_data = 0x00; no HALT.
- Saturate down: sat_mode = 1, load 0x01, up_dn = 0, run → count reaches 0x00 with no tc; next cycle tc = 1, state HALT; count stays 0x00; start is ignored; load 0x10 → IDLE with count = 0x10.
- Backpressure: wrap mode, load 0xFF, evt_ready = 0, count through two wraps (up from 0xFF, then 256 steps) → evt_data stays 0x00 from the first event and evt_ovf = 1. Set evt_ready = 1 → one transfer, then evt_valid = 0. clr_ovf → evt_ovf = 0.
- Priority: load = 1 with load_val = 0x00 and en = 1 while count = 0xFF, up, wrap mode → count = 0x00, no tc. Start and stop together in IDLE → stays IDLE.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared types and helpers for the up/down counter core.
// No logic; states, default width and the count bound helper.
// No flow control of its own.
package cnt_pkg;

    typedef enum logic [1:0] {
        CNT_IDLE = 2'd0,
        CNT_RUN  = 2'd1,
        CNT_HALT = 2'd2
    } cnt_state_e;

    localparam int CNT_WIDTH_DEF = 8;

    // Largest count value for a given width (2^width - 1), widths up to 64.
    function automatic logic [63:0] cnt_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/cnt_evt_reg.sv
// Single-entry valid/ready holding register for counter events with drop detection.
// Latency 1: a push shows up on evt_valid/evt_data the cycle after it is presented.
// Backpressure: push while full and not draining is dropped and sets sticky evt_ovf.
module cnt_evt_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             clr_ovf,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_data,
    output logic             evt_ovf
);

    logic accept;
    logic drop;

    // A slot is available when empty or when the held entry drains this cycle.
    assign accept = push && (!evt_valid || evt_ready);
    assign drop   = push && evt_valid && !evt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_data  <= '0;
            evt_ovf   <= 1'b0;
        end else begin
            if (accept) begin
                evt_valid <= 1'b1;
                evt_data  <= push_dat;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end

            if (drop) begin
                evt_ovf <= 1'b1;
            end else if (clr_ovf) begin
                evt_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cnt_updown_core.sv
// Loadable up/down counter with run/stop FSM, wrap/saturate modes and an event port.
// Latency 1: count, tc and the event port update on the edge after the sampled inputs.
// Backpressure: evt_ready low holds one event; further events are dropped and flagged.
module cnt_updown_core
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             tc,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_data,
    input  logic             evt_ready,
    output logic             evt_ovf
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));

    cnt_state_e       state_q;
    cnt_state_e       state_d;
    logic [WIDTH-1:0] count_d;
    logic             step;
    logic             at_bound;
    logic             evt;
    logic             sat_hit;

    always_comb begin
        state_d  = state_q;
        count_d  = count;
        evt      = 1'b0;
        sat_hit  = 1'b0;
        step     = (state_q == CNT_RUN) && en && !load;
        at_bound = up_dn ? (count == CNT_MAX) : (count == '0);

        if (load) begin
            count_d = load_val;
        end else if (step) begin
            if (at_bound) begin
                evt = 1'b1;
                // Saturation holds the value and parks the FSM until reloaded.
                if (sat_mode) begin
                    sat_hit = 1'b1;
                end else begin
                    count_d = up_dn ? '0 : CNT_MAX;
                end
            end else begin
                count_d = up_dn ? count + 1'b1 : count - 1'b1;
            end
        end

        case (state_q)
            CNT_IDLE: if (start && !stop) state_d = CNT_RUN;
            CNT_RUN: begin
                if (stop) begin
                    state_d = CNT_IDLE;
                end else if (sat_hit) begin
                    state_d = CNT_HALT;
                end
            end
            CNT_HALT: if (load) state_d = CNT_IDLE;
            default:  state_d = CNT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CNT_IDLE;
            count   <= '0;
            running <= 1'b0;
            tc      <= 1'b0;
        end else begin
            state_q <= state_d;
            count   <= count_d;
            running <= (state_d == CNT_RUN);
            tc      <= evt;
        end
    end

    cnt_evt_reg #(
        .WIDTH (WIDTH)
    ) u_evt_reg (
        .clk       (clk),
        .rst       (rst),
        .push      (evt),
        .push_dat  (count_d),
        .clr_ovf   (clr_ovf),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ovf   (evt_ovf)
    );

endmodule

// File: tb/tb_cnt_updown_core.sv
// Table-driven bench for cnt_updown_core; expectations queue on drive, compare after the edge.
module tb_cnt_updown_core;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       stop;
        logic       en;
        logic       up_dn;
        logic       sat_mode;
        logic       load;
        logic [7:0] load_val;
        logic       clr_ovf;
        logic       evt_ready;
    } in_t;

    typedef struct packed {
        logic [7:0] count;
        logic       running;
        logic       tc;
        logic       evt_valid;
        logic [7:0] evt_data;
        logic       evt_ovf;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       sat_mode = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       evt_ready = 1'b1;
    logic [7:0] count;
    logic       running;
    logic       tc;
    logic       evt_valid;
    logic [7:0] evt_data;
    logic       evt_ovf;

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    cnt_updown_core #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .up_dn     (up_dn),
        .sat_mode  (sat_mode),
        .load      (load),
        .load_val  (load_val),
        .clr_ovf   (clr_ovf),
        .count     (count),
        .running   (running),
        .tc        (tc),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ready (evt_ready),
        .evt_ovf   (evt_ovf)
    );

    // c = {rst,start,stop,en,up_dn,sat_mode,load}, cr = {clr_ovf,evt_ready},
    // f = {running,tc,evt_valid,evt_ovf}
    function automatic vec_t mk(input logic [6:0] c, input logic [7:0] lv,
                                input logic [1:0] cr, input logic [7:0] cnt,
                                input logic [3:0] f, input logic [7:0] ed);
        vec_t v;
        v.i = {c, lv, cr};
        v.o = {cnt, f[3], f[2], f[1], ed, f[0]};
        return v;
    endfunction

    task automatic apply(input string nm, input vec_t v);
        out_t got;
        out_t exp;
        @(negedge clk);
        {rst, start, stop, en, up_dn, sat_mode, load, load_val, clr_ovf, evt_ready} = v.i;
        exp_q.push_back(v.o);
        @(posedge clk);
        #1;
        got = {count, running, tc, evt_valid, evt_data, evt_ovf};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got cnt=%h run=%b tc=%b vld=%b dat=%h ovf=%b, want cnt=%h run=%b tc=%b vld=%b dat=%h ovf=%b",
                     nm, got.count, got.running, got.tc, got.evt_valid, got.evt_data, got.evt_ovf,
                     exp.count, exp.running, exp.tc, exp.evt_valid, exp.evt_data, exp.evt_ovf);
        end
    endtask

    initial begin
        // reset, wrap up from 0xFE
        tbl.push_back(mk(7'b1000100, 8'h00, 2'b01, 8'h00, 4'b0000, 8'h00));
        tbl.push_back(mk(7'b0000101, 8'hFE, 2'b01, 8'hFE, 4'b0000, 8'h00));
        tbl.push_back(mk(7'b0100100, 8'h00, 2'b01, 8'hFE, 4'b1000, 8'h00));
        tbl.push_back(mk(7'b0001100, 8'h00, 2'b01, 8'hFF, 4'b1000, 8'h00));
        tbl.push_back(mk(7'b0001100, 8'h00, 2'b01, 8'h00, 4'b1110, 8'h00));
        tbl.push_back(mk(7'b0001100, 8'h00, 2'b01, 8'h01, 4'b1000, 8'h00));
        tbl.push_back(mk(7'b0010100, 8'h00, 2'b01, 8'h01, 4'b0000, 8'h00));
        // saturate down, HALT, start ignored, load exits to IDLE
        tbl.push_back(mk(7'b0000011, 8'h01, 2'b01, 8'h01, 4'b0000, 8'h00));
        tbl.push_back(mk(7'b0100010, 8'h00, 2'b01, 8'h01, 4'b1000, 8'h00));
        tbl.push_back(mk(7'b0001010, 8'h00, 2'b01, 8'h00, 4'b1000, 8'h00));
        tbl.push_back(mk(7'b0001010, 8'h00, 2'b01, 8'h00, 4'b0110, 8'h00));
        tbl.push_back(mk(7'b0101010, 8'h00, 2'b01, 8'h00, 4'b0000, 8'h00));
        tbl.push_back(mk(7'b0000011, 8'h10, 2'b01, 8'h10, 4'b0000, 8'h00));
        tbl.push_back(mk(7'b0100100, 8'h00, 2'b01, 8'h10, 4'b1000, 8'h00));
        tbl.push_back(mk(7'b0010100, 8'h00, 2'b01, 8'h10, 4'b0000, 8'h00));
        // load beats step, start+stop stays IDLE
        tbl.push_back(mk(7'b0000101, 8'hFF, 2'b01, 8'hFF, 4'b0000, 8'h00));
        tbl.push_back(mk(7'b0100100, 8'h00, 2'b01, 8'hFF, 4'b1000, 8'h00));
        tbl.push_back(mk(7'b0001101, 8'h00, 2'b01, 8'h00, 4'b1000, 8'h00));
        tbl.push_back(mk(7'b0010100, 8'h00, 2'b01, 8'h00, 4'b0000, 8'h00));
        tbl.push_back(mk(7'b0110100, 8'h00, 2'b01, 8'h00, 4'b0000, 8'h00));
        // push on drain, drop with clr in same cycle, clear, drain
        tbl.push_back(mk(7'b0000101, 8'hFF, 2'b01, 8'hFF, 4'b0000, 8'h00));
        tbl.push_back(mk(7'b0100100, 8'h00, 2'b01, 8'hFF, 4'b1000, 8'h00));
        tbl.push_back(mk(7'b0001100, 8'h00, 2'b00, 8'h00, 4'b1110, 8'h00));
        tbl.push_back(mk(7'b0001000, 8'h00, 2'b01, 8'hFF, 4'b1110, 8'hFF));
        tbl.push_back(mk(7'b0001100, 8'h00, 2'b10, 8'h00, 4'b1111, 8'hFF));
        tbl.push_back(mk(7'b0000100, 8'h00, 2'b10, 8'h00, 4'b1010, 8'hFF));
        tbl.push_back(mk(7'b0000100, 8'h00, 2'b01, 8'h00, 4'b1000, 8'hFF));
        tbl.push_back(mk(7'b0010100, 8'h00, 2'b01, 8'h00, 4'b0000, 8'hFF));

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // backpressure over two wraps
        apply("bp_load",  mk(7'b0000101, 8'hFF, 2'b00, 8'hFF, 4'b0000, 8'hFF));
        apply("bp_start", mk(7'b0100100, 8'h00, 2'b00, 8'hFF, 4'b1000, 8'hFF));
        apply("bp_wrap1", mk(7'b0001100, 8'h00, 2'b00, 8'h00, 4'b1110, 8'h00));
        for (int k = 1; k <= 256; k++) begin
            apply($sformatf("bp_step%0d", k),
                  mk(7'b0001100, 8'h00, 2'b00, 8'(k), {1'b1, k == 256, 1'b1, k == 256}, 8'h00));
        end
        apply("bp_drain", mk(7'b0000100, 8'h00, 2'b01, 8'h00, 4'b1001, 8'h00));
        apply("bp_once",  mk(7'b0000100, 8'h00, 2'b01, 8'h00, 4'b1001, 8'h00));
        apply("bp_clr",   mk(7'b0000100, 8'h00, 2'b11, 8'h00, 4'b1000, 8'h00));

        // reset mid-operation with an event pending
        apply("rs_load", mk(7'b0000101, 8'hFF, 2'b00, 8'hFF, 4'b1000, 8'h00));
        apply("rs_evt",  mk(7'b0001100, 8'h00, 2'b00, 8'h00, 4'b1110, 8'h00));
        apply("rs_37",   mk(7'b0000101, 8'h37, 2'b00, 8'h37, 4'b1010, 8'h00));
        apply("rs_rst",  mk(7'b1101101, 8'hAA, 2'b11, 8'h00, 4'b0000, 8'h00));
        apply("rs_idle", mk(7'b0001100, 8'h00, 2'b01, 8'h00, 4'b0000, 8'h00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
